// File: rtl/rf_arb_pkg.sv
// Shared widths and the buffered-result entry type for the register-file write-port arbiter.
package rf_arb_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } rf_entry_t;

   // Width of a counter that must hold 0..n inclusive.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Shift-style FIFO of MDU results; entry 0 is always the head, entries are valid as a thermometer.
module wb_fifo
   import rf_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CntW = cnt_w(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [REG_AW-1:0]       push_rd,
   input  logic [XLEN-1:0]         push_data,
   input  logic                    pop,
   output logic [CntW-1:0]         count,
   output logic [REG_AW-1:0]       head_rd,
   output logic [XLEN-1:0]         head_data,
   output logic [DEPTH-1:0]        ent_valid,
   output logic [DEPTH*REG_AW-1:0] ent_rd
);

   rf_entry_t        mem_q [DEPTH];
   rf_entry_t        mem_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CntW-1:0]  count_q, count_d, wr_idx;

   // A simultaneous pop shifts everything down, so the new entry lands one slot lower.
   assign wr_idx = count_q - CntW'(pop);

   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      if (pop) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            mem_d[i]   = mem_q[i+1];
            valid_d[i] = valid_q[i+1];
         end
         valid_d[DEPTH-1] = 1'b0;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (push && wr_idx == CntW'(i)) begin
            mem_d[i]   = '{rd: push_rd, data: push_data};
            valid_d[i] = 1'b1;
         end
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      ent_rd = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ent_rd[i*REG_AW +: REG_AW] = mem_q[i].rd;
      end
   end

   assign count     = count_q;
   assign head_rd   = mem_q[0].rd;
   assign head_data = mem_q[0].data;
   assign ent_valid = valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the WB stage and buffered MDU results.
// Define WB_ARB_STARVE_EN to stall the pipeline when a buffered result has waited MAX_WAIT cycles.
module wb_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [REG_AW-1:0] mdu_rd,
   input  logic [XLEN-1:0]   mdu_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_a3,
   output logic [XLEN-1:0]   rf_wd,
   output logic              pipe_stall,
   output logic [31:0]       pending_mask
);

   localparam int unsigned CntW = cnt_w(DEPTH);

   logic [CntW-1:0]         count;
   logic [REG_AW-1:0]       head_rd;
   logic [XLEN-1:0]         head_data;
   logic [DEPTH-1:0]        ent_valid;
   logic [DEPTH*REG_AW-1:0] ent_rd;
   logic                    fifo_empty;
   logic                    push;
   logic                    head_grant;

   assign fifo_empty = (count == '0);
   assign mdu_ready  = !rst && (count < CntW'(DEPTH));
   // Results for x0 are acknowledged but never buffered.
   assign push       = mdu_valid && mdu_ready && (mdu_rd != '0);

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_rd   (mdu_rd),
      .push_data (mdu_data),
      .pop       (head_grant),
      .count     (count),
      .head_rd   (head_rd),
      .head_data (head_data),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd)
   );

`ifdef WB_ARB_STARVE_EN
   localparam int unsigned WaitW = cnt_w(MAX_WAIT);

   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      if (fifo_empty || head_grant) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WaitW'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign pipe_stall = !fifo_empty && (wait_cnt_q == WaitW'(MAX_WAIT));
`else
   logic unused_max_wait;

   assign unused_max_wait = ^MAX_WAIT;
   assign pipe_stall      = 1'b0;
`endif

   always_comb begin
      head_grant = 1'b0;
      rf_we      = 1'b0;
      rf_a3      = '0;
      rf_wd      = '0;
      if (pipe_stall && !fifo_empty) begin
         head_grant = 1'b1;
      end else if (wb_we && wb_rd != '0) begin
         rf_we = 1'b1;
         rf_a3 = wb_rd;
         rf_wd = wb_data;
      end else if (!fifo_empty) begin
         head_grant = 1'b1;
      end
      if (head_grant) begin
         rf_we = 1'b1;
         rf_a3 = head_rd;
         rf_wd = head_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (ent_valid[i]) begin
            pending_mask[ent_rd[i*REG_AW +: REG_AW]] = 1'b1;
         end
      end
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: the driver predicts each cycle from a queue-based model, a monitor compares.
module tb_wb_port_arbiter;

   localparam int unsigned DEPTH    = 2;
   localparam int unsigned MAX_WAIT = 4;
`ifdef WB_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        mdu_valid = 1'b0;
   logic        mdu_ready;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_data = '0;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;
   logic        pipe_stall;
   logic [31:0] pending_mask;

   wb_port_arbiter #(
      .DEPTH    (DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .mdu_valid    (mdu_valid),
      .mdu_ready    (mdu_ready),
      .mdu_rd       (mdu_rd),
      .mdu_data     (mdu_data),
      .rf_we        (rf_we),
      .rf_a3        (rf_a3),
      .rf_wd        (rf_wd),
      .pipe_stall   (pipe_stall),
      .pending_mask (pending_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        we;
      logic        ready;
      logic        stall;
      logic [31:0] mask;
   } st_t;

   ent_t mq[$];     // model of buffered results, head first
   int   waitc = 0; // cycles the model head has waited
   st_t  st_q[$];   // per-cycle expected status
   ent_t wr_q[$];   // expected writes in grant order

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle and predict its combinational outputs, then advance the model past the edge.
   task automatic step(input bit r, input bit we, input bit [4:0] wrd, input bit [31:0] wd,
                       input bit mv, input bit [4:0] mrd, input bit [31:0] md);
      st_t  e;
      bit   head_g;
      int   n;
      @(posedge clk);
      #1;
      rst = r; wb_we = we; wb_rd = wrd; wb_data = wd;
      mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
      n       = mq.size();
      e.ready = !r && (n < int'(DEPTH));
      e.stall = STARVE && (n > 0) && (waitc == int'(MAX_WAIT));
      e.mask  = '0;
      foreach (mq[i]) e.mask[mq[i].rd] = 1'b1;
      e.mask[0] = 1'b0;
      head_g = (n > 0) && (e.stall || !(we && wrd != 0));
      e.we   = head_g || (we && wrd != 0);
      st_q.push_back(e);
      if (head_g) wr_q.push_back(mq[0]);
      else if (e.we) wr_q.push_back('{rd: wrd, data: wd});
      if (r) begin
         mq.delete();
         waitc = 0;
      end else begin
         if (head_g) void'(mq.pop_front());
         if (mv && e.ready && mrd != 0) mq.push_back('{rd: mrd, data: md});
         if (head_g || n == 0) waitc = 0;
         else if (waitc < int'(MAX_WAIT)) waitc++;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      st_t  s;
      ent_t w;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         chk("rf_we", 32'(rf_we), 32'(s.we));
         chk("mdu_ready", 32'(mdu_ready), 32'(s.ready));
         chk("pipe_stall", 32'(pipe_stall), 32'(s.stall));
         chk("pending_mask", pending_mask, s.mask);
         if (rf_we) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got rf_a3=%0d rf_wd=0x%08h, expected no write",
                        rf_a3, rf_wd);
            end else begin
               w = wr_q.pop_front();
               chk("rf_a3", 32'(rf_a3), 32'(w.rd));
               chk("rf_wd", rf_wd, w.data);
            end
         end
      end
   end

   initial begin
      // Reset
      step(1, 0, 0, 0, 0, 0, 0);
      sample();
      chk("rst_ready", 32'(mdu_ready), 32'd0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle();
      sample();
      chk("post_rst_ready", 32'(mdu_ready), 32'd1);
      chk("post_rst_we", 32'(rf_we), 32'd0);
      chk("post_rst_mask", pending_mask, 32'd0);
      chk("post_rst_stall", 32'(pipe_stall), 32'd0);

      // Zero-latency WB write
      step(0, 1, 5, 32'hA5A5_A5A5, 0, 0, 0);
      sample();
      chk("wb_we", 32'(rf_we), 32'd1);
      chk("wb_a3", 32'(rf_a3), 32'd5);
      chk("wb_wd", rf_wd, 32'hA5A5_A5A5);

      // Single MDU result written the cycle after acceptance
      step(0, 0, 0, 0, 1, 7, 32'h12);
      sample();
      chk("mdu_accept_cycle_we", 32'(rf_we), 32'd0);
      idle();
      sample();
      chk("mdu_we", 32'(rf_we), 32'd1);
      chk("mdu_a3", 32'(rf_a3), 32'd7);
      chk("mdu_wd", rf_wd, 32'h12);
      chk("mdu_mask7", pending_mask, 32'h80);
      idle();
      sample();
      chk("mdu_mask_clear", pending_mask, 32'd0);

      // FIFO fills while WB is busy; third result held until a pop
      step(0, 1, 1, 32'h111, 1, 3, 32'h33);
      step(0, 1, 1, 32'h222, 1, 4, 32'h44);
      step(0, 1, 1, 32'h333, 1, 10, 32'hAA);
      sample();
      chk("full_ready", 32'(mdu_ready), 32'd0);
      chk("full_mask", pending_mask, 32'h18);
      step(0, 1, 1, 32'h444, 1, 10, 32'hAA);
      step(0, 0, 0, 0, 1, 10, 32'hAA);
      sample();
      chk("full_pop_a3", 32'(rf_a3), 32'd3);
      chk("full_pop_ready", 32'(mdu_ready), 32'd0);
      step(0, 0, 0, 0, 1, 10, 32'hAA);
      sample();
      chk("after_pop_ready", 32'(mdu_ready), 32'd1);
      chk("after_pop_a3", 32'(rf_a3), 32'd4);
      idle();
      sample();
      chk("held_result_a3", 32'(rf_a3), 32'd10);
      idle();
      idle();

      // Result for x0 is dropped
      step(0, 0, 0, 0, 1, 0, 32'hDEAD);
      idle();
      sample();
      chk("x0_no_write", 32'(rf_we), 32'd0);
      chk("x0_mask", pending_mask, 32'd0);

      // Reset with two results buffered drops them
      step(0, 1, 2, 32'h1, 1, 11, 32'hB);
      step(0, 1, 2, 32'h2, 1, 12, 32'hC);
      step(0, 1, 2, 32'h3, 0, 0, 0);
      sample();
      chk("pre_rst_mask", pending_mask, 32'h1800);
      step(1, 1, 2, 32'h4, 0, 0, 0);
      idle();
      sample();
      chk("rst_drop_mask", pending_mask, 32'd0);
      chk("rst_drop_we", 32'(rf_we), 32'd0);

`ifdef WB_ARB_STARVE_EN
      // Starved result forces a stall slot after MAX_WAIT cycles
      step(0, 1, 1, 32'h50, 1, 9, 32'h99);
      for (int k = 0; k < int'(MAX_WAIT); k++) begin
         step(0, 1, 1, 32'h50, 0, 0, 0);
         sample();
         chk("starve_wait_stall", 32'(pipe_stall), 32'd0);
      end
      step(0, 1, 1, 32'h50, 0, 0, 0);
      sample();
      chk("starve_stall", 32'(pipe_stall), 32'd1);
      chk("starve_a3", 32'(rf_a3), 32'd9);
      step(0, 1, 1, 32'h50, 0, 0, 0);
      sample();
      chk("starve_release", 32'(pipe_stall), 32'd0);
      chk("starve_wb_a3", 32'(rf_a3), 32'd1);
      idle();
`endif

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         bit [4:0] mrd;
         mrd = 5'($urandom);
         if ($urandom_range(0, 5) == 0) mrd = '0;
         step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
              $urandom_range(0, 2) != 0, mrd, $urandom);
      end
      idle();
      sample();
      sample();
      chk("write_queue_drained", 32'(wr_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered multi-cycle-unit (MDU) results.
REQ-002 SHALL have parameter MAX_WAIT, default 4, cycles a buffered result may wait before a forced write slot.
REQ-003 SHALL have a single clock: clk  in  1  rising-edge clock.
REQ-004 SHALL have rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have wb_we  in  1  pipeline WB-stage write request.
REQ-006 SHALL have wb_rd  in  5  pipeline destination register.
REQ-007 SHALL have wb_data  in  32  pipeline write data.
REQ-008 SHALL have mdu_valid  in  1  MDU result valid.
REQ-009 SHALL have mdu_ready  out  1  arbiter can accept an MDU result.
REQ-010 SHALL have mdu_rd  in  5  MDU destination register.
REQ-011 SHALL have mdu_data  in  32  MDU result data.
REQ-012 SHALL have rf_we  out  1  register-file write enable.
REQ-013 SHALL have rf_a3  out  5  register-file write address.
REQ-014 SHALL have rf_wd  out  32  register-file write data.
REQ-015 SHALL have pipe_stall  out  1  pipeline must hold its WB instruction this cycle.
REQ-016 SHALL have pending_mask  out  32  bit n set while a buffered MDU result targets xn.

Function
REQ-017 SHALL accept an MDU result on a rising edge where mdu_valid=1 and mdu_ready=1, pushing {rd, data} into a FIFO of DEPTH entries.
REQ-018 SHALL drive mdu_ready = 1 when FIFO count < DEPTH; no acceptance when full, even if a dequeue occurs that cycle.
REQ-019 SHALL discard an accepted result with mdu_rd=0: no FIFO entry, no write.
REQ-020 SHALL compute rf_we/rf_a3/rf_wd combinationally each cycle by priority: (1) pipe_stall=1 and FIFO non-empty -> FIFO head; (2) wb_we=1 and wb_rd!=0 -> WB inputs; (3) FIFO non-empty -> FIFO head; (4) rf_we=0, rf_a3=0, rf_wd=0.
REQ-021 SHALL pop the FIFO head on the rising edge ending a cycle in which the head was granted.
REQ-022 SHALL give WB-path writes zero latency; an MDU result is writable no earlier than the cycle after acceptance.
REQ-023 SHALL ignore wb_we while pipe_stall=1; the pipeline re-presents the same write next cycle.
REQ-024 SHALL perform no RAW/WAW reordering; writes retire in grant order and hazards are resolved externally using pending_mask.
REQ-025 SHALL form pending_mask as the OR of one-hot(rd) over valid FIFO entries, from registered state only; bit 0 always 0.
REQ-026 SHALL keep a wait counter: cleared on pop or when empty, incremented (saturating at MAX_WAIT) each cycle the FIFO is non-empty and not popped.

Reset
REQ-027 SHALL, while rst=1 at a rising edge, empty the FIFO and clear the wait counter; mdu_ready=0 during rst, 1 on the first cycle after.
REQ-028 SHALL drive rf_we=0, rf_a3=0, rf_wd=0, pipe_stall=0, pending_mask=0 while FIFO is empty after reset; reset mid-operation drops all buffered results without writing them.

Configuration
REQ-029 SHALL, with WB_ARB_STARVE_EN defined, drive pipe_stall = 1 when wait counter == MAX_WAIT and FIFO non-empty, deasserting the cycle after the pop.
REQ-030 SHALL, without WB_ARB_STARVE_EN, tie pipe_stall to 0 and omit the wait counter; MDU results write only in WB-idle cycles.

Structure
REQ-031 SHALL take XLEN=32, REG_AW=5 and the {rd, data} entry struct from shared package rf_arb_pkg.
REQ-032 SHALL implement buffering in one sub-module, wb_fifo (parameterised by DEPTH, exposing count, head, and per-entry valid/rd for pending_mask).

Verification
REQ-033 SHALL cover: wb_we=1, wb_rd=5, wb_data=0xA5A5A5A5, FIFO empty -> same cycle rf_we=1, rf_a3=5, rf_wd=0xA5A5A5A5.
REQ-034 SHALL cover: MDU accepts rd=7, data=0x12 with WB idle -> next cycle rf_we=1, rf_a3=7, pending_mask[7]=1; cycle after, pending_mask=0.
REQ-035 SHALL cover: two MDU results (rd=3, rd=4) accepted back-to-back while WB busy every cycle -> mdu_ready=0 after the second; third mdu_valid held, not accepted until a pop.
REQ-036 SHALL cover (WB_ARB_STARVE_EN, MAX_WAIT=4): rd=9 buffered, WB busy continuously -> pipe_stall=1 after 4 waiting cycles, rf_a3=9 that cycle, pipe_stall=0 next cycle and held WB write then retires.
REQ-037 SHALL cover: mdu_rd=0 accepted -> no write, pending_mask unchanged; and rst=1 asserted with 2 entries buffered -> next cycle FIFO empty, pending_mask=0, rf_we=0.
